// File: rtl/implication_window_monitor_pkg.sv
// impl_mon_pkg: shared limits and helpers for the bounded implication monitor
package impl_mon_pkg;

    localparam int MAX_DLY_LIMIT = 63;
    localparam int PEND_W        = 7;

    function automatic logic [PEND_W-1:0] popcount(input logic [63:0] v);
        logic [PEND_W-1:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) n += PEND_W'(v[i]);
        return n;
    endfunction

    // Saturating add; the wide sum keeps the carry so overflow is detected rather than wrapped
    function automatic logic [63:0] sat_add(input logic [63:0] cnt, input logic [63:0] inc, input int width);
        logic [64:0] sum;
        logic [63:0] lim;
        lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        sum = {1'b0, cnt} + {1'b0, inc};
        return (sum > {1'b0, lim}) ? lim : sum[63:0];
    endfunction

endpackage

// File: rtl/implication_window_monitor_if.sv
// implication_window_monitor_if: sampled conditions in, verdicts and totals out
interface implication_window_monitor_if #(parameter int CNT_W = 16);
    import impl_mon_pkg::*;

    logic              en;
    logic              clear;
    logic              ante;
    logic              cons;
    logic              pass_o;
    logic              fail_o;
    logic [CNT_W-1:0]  pass_total;
    logic [CNT_W-1:0]  fail_total;
    logic [PEND_W-1:0] pending;
    logic              busy;

    modport master (
        output en, clear, ante, cons,
        input  pass_o, fail_o, pass_total, fail_total, pending, busy
    );

    modport slave (
        input  en, clear, ante, cons,
        output pass_o, fail_o, pass_total, fail_total, pending, busy
    );

endinterface

// File: rtl/implication_window_monitor_sat_counter.sv
// sat_counter: accumulator that sticks at all-ones instead of wrapping
module sat_counter
    import impl_mon_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] cnt
);

    // Add the increment each cycle, clamping at the top of the range
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= CNT_W'(sat_add(64'(cnt), 64'(inc), CNT_W));
    end

endmodule

// File: rtl/implication_window_monitor.sv
// implication_window_monitor: hardware checker for ante |-> ##[MIN_DLY:MAX_DLY] cons
module implication_window_monitor
    import impl_mon_pkg::*;
#(
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 10,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    implication_window_monitor_if.slave mon
);

    // Bit a of the age vector is an attempt started a enabled cycles ago; bit 0 of
    // pend_q is never set, so OR-ing ante into it yields the full live vector.
    localparam int W = MAX_DLY + 1;
    localparam logic [W-1:0] WIN = {W{1'b1}} << MIN_DLY;

    logic [W-1:0]      pend_q;
    logic [W-1:0]      live;
    logic [W-1:0]      hit;
    logic [W-1:0]      nxt;
    logic              miss;
    logic              adv;
    logic [PEND_W-1:0] pass_inc;
    logic              fail_inc;

    if ((MIN_DLY < 0) || (MIN_DLY > MAX_DLY) || (MAX_DLY > MAX_DLY_LIMIT)) begin : g_bad_params
        $error("implication_window_monitor: need 0 <= MIN_DLY <= MAX_DLY <= %0d", MAX_DLY_LIMIT);
    end

    // Discharge every in-window attempt on cons, expire the oldest, and age the rest by one
    always_comb begin
        adv      = mon.en & ~mon.clear;
        live     = pend_q | W'(mon.ante);
        hit      = live & WIN & {W{mon.cons}};
        miss     = live[MAX_DLY] & ~mon.cons;
        nxt      = (live & ~hit) << 1;
        pass_inc = adv ? popcount(64'(hit)) : '0;
        fail_inc = adv & miss;
    end

    // Commit the update only on enabled cycles; clear flushes attempts and verdict pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= '0;
            mon.pass_o  <= 1'b0;
            mon.fail_o  <= 1'b0;
            mon.pending <= '0;
            mon.busy    <= 1'b0;
        end else if (mon.en) begin
            pend_q      <= mon.clear ? '0 : nxt;
            mon.pass_o  <= ~mon.clear & (|hit);
            mon.fail_o  <= ~mon.clear & miss;
            mon.pending <= mon.clear ? '0 : popcount(64'(nxt));
            mon.busy    <= ~mon.clear & (|nxt);
        end
    end

    sat_counter #(.CNT_W(CNT_W), .INC_W(PEND_W)) u_pass_total (
        .clk (clk),
        .rst (rst),
        .inc (pass_inc),
        .cnt (mon.pass_total)
    );

    sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_fail_total (
        .clk (clk),
        .rst (rst),
        .inc (fail_inc),
        .cnt (mon.fail_total)
    );

endmodule

// File: tb/tb_implication_window_monitor.sv
// tb_implication_window_monitor: directed checks of the implication monitor in several configurations
module tb_implication_window_monitor;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    implication_window_monitor_if #(.CNT_W(16)) i0   ();
    implication_window_monitor_if #(.CNT_W(16)) i10  ();
    implication_window_monitor_if #(.CNT_W(16)) i3   ();
    implication_window_monitor_if #(.CNT_W(4))  isat ();

    implication_window_monitor #(.MIN_DLY(0), .MAX_DLY(0),  .CNT_W(16)) d0   (.clk(clk), .rst(rst), .mon(i0));
    implication_window_monitor #(.MIN_DLY(1), .MAX_DLY(10), .CNT_W(16)) d10  (.clk(clk), .rst(rst), .mon(i10));
    implication_window_monitor #(.MIN_DLY(1), .MAX_DLY(3),  .CNT_W(16)) d3   (.clk(clk), .rst(rst), .mon(i3));
    implication_window_monitor #(.MIN_DLY(0), .MAX_DLY(0),  .CNT_W(4))  dsat (.clk(clk), .rst(rst), .mon(isat));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        {i0.en, i10.en, i3.en, isat.en} = 4'hF;
        {i0.clear, i10.clear, i3.clear, isat.clear} = 4'h0;
        {i0.ante, i10.ante, i3.ante, isat.ante} = 4'h0;
        {i0.cons, i10.cons, i3.cons, isat.cons} = 4'h0;
        step();
        step();
        chk("rst_pass_o", i10.pass_o, 0);
        chk("rst_fail_o", i10.fail_o, 0);
        chk("rst_pass_total", i10.pass_total, 0);
        chk("rst_fail_total", i10.fail_total, 0);
        chk("rst_pending", i10.pending, 0);
        chk("rst_busy", i10.busy, 0);
        rst = 1'b0;

        // 1: same-cycle check, x==0 and y==0 only in cycle 0
        for (int c = 0; c < 4; c++) begin
            i0.ante = (c == 0);
            i0.cons = (2 * c == 0);
            step();
            chk($sformatf("t1_pass_o_c%0d", c), i0.pass_o, (c == 0));
            chk($sformatf("t1_pending_c%0d", c), i0.pending, 0);
            chk($sformatf("t1_pass_total_c%0d", c), i0.pass_total, 1);
            chk($sformatf("t1_fail_total_c%0d", c), i0.fail_total, 0);
        end
        i0.ante = 1'b0;
        i0.cons = 1'b0;

        // 2: attempt at x==1 discharged by y==20 at age 9
        for (int c = 0; c < 13; c++) begin
            i10.ante = (c == 1);
            i10.cons = (2 * c == 20);
            step();
            chk($sformatf("t2_busy_c%0d", c), i10.busy, (c >= 1 && c <= 9));
            chk($sformatf("t2_pass_o_c%0d", c), i10.pass_o, (c == 10));
        end
        chk("t2_pass_total", i10.pass_total, 1);
        chk("t2_fail_total", i10.fail_total, 0);

        // 3: attempt at x==0 expires at age 3 before y reaches 20
        do_reset();
        for (int c = 0; c < 6; c++) begin
            i3.ante = (c == 0);
            i3.cons = (2 * c == 20);
            step();
            chk($sformatf("t3_pending_c%0d", c), i3.pending, (c <= 2));
            chk($sformatf("t3_fail_o_c%0d", c), i3.fail_o, (c == 3));
        end
        chk("t3_fail_total", i3.fail_total, 1);
        chk("t3_pass_total", i3.pass_total, 0);

        // 4: five overlapping attempts discharged by one cons pulse
        do_reset();
        for (int c = 0; c < 8; c++) begin
            i10.ante = (c <= 4);
            i10.cons = (c == 5);
            step();
            chk($sformatf("t4_pending_c%0d", c), i10.pending, (c <= 4) ? c + 1 : 0);
            chk($sformatf("t4_pass_o_c%0d", c), i10.pass_o, (c == 5));
        end
        chk("t4_pass_total", i10.pass_total, 5);
        chk("t4_fail_total", i10.fail_total, 0);
        i10.ante = 1'b0;
        i10.cons = 1'b0;

        // 5: enable gap freezes ageing; stray pulses and clear while disabled are ignored
        do_reset();
        for (int c = 0; c < 11; c++) begin
            i3.en    = !(c >= 2 && c <= 6) && (c != 9);
            i3.ante  = (c == 0) || (c == 4);
            i3.cons  = (c == 3) || (c == 5);
            i3.clear = (c == 5);
            step();
            chk($sformatf("t5_pending_c%0d", c), i3.pending, (c <= 7));
            chk($sformatf("t5_fail_o_c%0d", c), i3.fail_o, (c == 8 || c == 9));
            chk($sformatf("t5_pass_o_c%0d", c), i3.pass_o, 0);
        end
        chk("t5_fail_total", i3.fail_total, 1);
        chk("t5_pass_total", i3.pass_total, 0);

        // 6b: clear flushes attempts and pulses but keeps totals; no effect while disabled
        i3.en = 1'b1; i3.clear = 1'b0; i3.ante = 1'b1; i3.cons = 1'b0;
        step();
        chk("t6b_pending_c0", i3.pending, 1);
        i3.en = 1'b0; i3.clear = 1'b1; i3.ante = 1'b0;
        step();
        chk("t6b_pending_clear_dis", i3.pending, 1);
        i3.en = 1'b1; i3.clear = 1'b0; i3.ante = 1'b1; i3.cons = 1'b1;
        step();
        chk("t6b_pending_c2", i3.pending, 1);
        chk("t6b_pass_o_c2", i3.pass_o, 1);
        chk("t6b_pass_total_c2", i3.pass_total, 1);
        i3.clear = 1'b1;
        step();
        chk("t6b_pending_clear", i3.pending, 0);
        chk("t6b_busy_clear", i3.busy, 0);
        chk("t6b_pass_o_clear", i3.pass_o, 0);
        chk("t6b_pass_total_clear", i3.pass_total, 1);
        chk("t6b_fail_total_clear", i3.fail_total, 1);
        i3.clear = 1'b0; i3.ante = 1'b0; i3.cons = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("t6b_fail_o_after_c%0d", c), i3.fail_o, 0);
        end
        chk("t6b_fail_total_end", i3.fail_total, 1);

        // 6a: asynchronous reset mid-window discards three pending attempts
        do_reset();
        for (int c = 0; c < 5; c++) begin
            i10.ante = (c <= 2);
            i10.cons = 1'b0;
            step();
        end
        chk("t6a_pending_before", i10.pending, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6a_async_pending", i10.pending, 0);
        chk("t6a_async_busy", i10.busy, 0);
        chk("t6a_async_pass_o", i10.pass_o, 0);
        chk("t6a_async_fail_o", i10.fail_o, 0);
        chk("t6a_async_pass_total", i10.pass_total, 0);
        chk("t6a_async_fail_total", i3.fail_total, 0);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            chk($sformatf("t6a_fail_o_c%0d", c), i10.fail_o, 0);
        end
        chk("t6a_fail_total_end", i10.fail_total, 0);

        // Saturation of both totals with a 4-bit counter
        do_reset();
        isat.ante = 1'b1;
        isat.cons = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("sat_pass_total_c%0d", c), isat.pass_total, (c < 15) ? c + 1 : 15);
            chk($sformatf("sat_pass_o_c%0d", c), isat.pass_o, 1);
        end
        isat.cons = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("sat_fail_total_c%0d", c), isat.fail_total, (c < 15) ? c + 1 : 15);
            chk($sformatf("sat_fail_o_c%0d", c), isat.fail_o, 1);
        end
        chk("sat_pass_total_end", isat.pass_total, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
